// File: rtl/gen_sum_caller.sv
// Caller side of the generator handshake: launches a child generator with the
// upstream arguments, sums every yielded c_0, counts yields, returns (sum, count).
module gen_sum_caller #(
  parameter int WIDTH       = 32,
  parameter int STALL_EVERY = 0
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _start,
  input  logic             _ready,
  input  logic [WIDTH-1:0] base,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  output logic             _done,
  output logic             _valid,
  output logic [WIDTH-1:0] _0,
  output logic [WIDTH-1:0] _1,
  output logic             c_start,
  output logic             c_ready,
  output logic [WIDTH-1:0] c_base,
  output logic [WIDTH-1:0] c_limit,
  output logic [WIDTH-1:0] c_step,
  input  logic             c_done,
  input  logic             c_valid,
  input  logic [WIDTH-1:0] c_0,
  input  logic [WIDTH-1:0] c_1
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_COLLECT = 2'd2,
    ST_RESULT  = 2'd3
  } state_t;

  localparam logic             STALL_EN   = 1'(STALL_EVERY > 0);
  localparam logic [WIDTH-1:0] STALL_LAST = (STALL_EVERY > 0) ? WIDTH'(STALL_EVERY - 1)
                                                               : {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic             r_c_start;
  logic             r_c_ready;
  logic             r_result;
  logic [WIDTH-1:0] r_c_base;
  logic [WIDTH-1:0] r_c_limit;
  logic [WIDTH-1:0] r_c_step;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_stall_cnt;
  logic [WIDTH-1:0] r_res0;
  logic [WIDTH-1:0] r_res1;

  logic             w_accept;
  logic             w_complete;
  logic             w_stall_hit;
  logic             w_c_ready_next;
  logic             w_launch;
  logic [WIDTH-1:0] w_sum_next;
  logic [WIDTH-1:0] w_count_next;
  logic             w_unused_c1;

  // c_1 only matters to the child; the yield count comes from the handshake.
  assign w_unused_c1 = ^c_1;

  assign w_sum_next   = r_sum + c_0;
  assign w_count_next = r_count + ONE;

  // Next-state, handshake qualification and stall decision.
  always_comb begin
    w_next_state   = r_state;
    w_accept       = 1'b0;
    w_complete     = 1'b0;
    w_launch       = 1'b0;
    w_stall_hit    = 1'b0;
    w_c_ready_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (_start) begin
          w_launch     = 1'b1;
          w_next_state = ST_LAUNCH;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        w_accept     = c_valid && r_c_ready;
        w_next_state = ST_COLLECT;
      end
      ST_COLLECT: begin
        w_accept   = c_valid && r_c_ready;
        w_complete = c_done && r_c_ready;
        if (w_complete) begin
          w_next_state = ST_RESULT;
        end else begin
          w_next_state = ST_COLLECT;
        end
      end
      ST_RESULT: begin
        if (_ready) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_RESULT;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
    w_stall_hit = STALL_EN && w_accept && (r_stall_cnt == STALL_LAST);
    // A stall only ever costs one cycle of c_ready while still collecting.
    if (w_next_state == ST_LAUNCH) begin
      w_c_ready_next = 1'b1;
    end else if (w_next_state == ST_COLLECT) begin
      w_c_ready_next = !w_stall_hit;
    end else begin
      w_c_ready_next = 1'b0;
    end
  end

  // State, accumulators and registered outputs.
  always_ff @(posedge _clock) begin
    if (_reset) begin
      r_state     <= ST_IDLE;
      r_c_start   <= 1'b0;
      r_c_ready   <= 1'b0;
      r_result    <= 1'b0;
      r_c_base    <= {WIDTH{1'b0}};
      r_c_limit   <= {WIDTH{1'b0}};
      r_c_step    <= {WIDTH{1'b0}};
      r_sum       <= {WIDTH{1'b0}};
      r_count     <= {WIDTH{1'b0}};
      r_stall_cnt <= {WIDTH{1'b0}};
      r_res0      <= {WIDTH{1'b0}};
      r_res1      <= {WIDTH{1'b0}};
    end else begin
      r_state   <= w_next_state;
      r_c_start <= (w_next_state == ST_LAUNCH);
      r_c_ready <= w_c_ready_next;
      r_result  <= (w_next_state == ST_RESULT);
      if (w_launch) begin
        r_c_base    <= base;
        r_c_limit   <= limit;
        r_c_step    <= step;
        r_sum       <= {WIDTH{1'b0}};
        r_count     <= {WIDTH{1'b0}};
        r_stall_cnt <= {WIDTH{1'b0}};
      end else if (w_accept) begin
        r_sum   <= w_sum_next;
        r_count <= w_count_next;
        if (w_stall_hit) begin
          r_stall_cnt <= {WIDTH{1'b0}};
        end else begin
          r_stall_cnt <= r_stall_cnt + ONE;
        end
      end else begin
        r_sum       <= r_sum;
        r_count     <= r_count;
        r_stall_cnt <= r_stall_cnt;
      end
      // A yield riding on the completion edge is folded into the result.
      if (w_complete) begin
        r_res0 <= w_accept ? w_sum_next : r_sum;
        r_res1 <= w_accept ? w_count_next : r_count;
      end else begin
        r_res0 <= r_res0;
        r_res1 <= r_res1;
      end
    end
  end

  assign _done   = r_result;
  assign _valid  = r_result;
  assign _0      = r_res0;
  assign _1      = r_res1;
  assign c_start = r_c_start;
  assign c_ready = r_c_ready;
  assign c_base  = r_c_base;
  assign c_limit = r_c_limit;
  assign c_step  = r_c_step;

endmodule

// File: tb/tb_gen_sum_caller.sv
// Directed bench: two callers (no stall / stall every 2) share upstream stimulus,
// each driving its own behavioural range child.
module tb_gen_sum_caller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, rdy;
  logic [31:0] base, limit, step;
  logic        ov[2], od[2], cs[2], cr[2], cv[2], cd[2];
  logic [31:0] o0[2], o1[2], cb[2], cl[2], cst[2], c0[2], c1[2];
  logic        act[2];
  logic [31:0] cur[2], lim[2], stp[2];
  int          yields[2];
  logic        wrap_mode;
  int          total = 0;
  int          bad = 0;
  int          n;

  gen_sum_caller #(.WIDTH(32), .STALL_EVERY(0)) u_dut0 (
    ._clock(clk), ._reset(rst), ._start(start), ._ready(rdy),
    .base(base), .limit(limit), .step(step),
    ._done(od[0]), ._valid(ov[0]), ._0(o0[0]), ._1(o1[0]),
    .c_start(cs[0]), .c_ready(cr[0]), .c_base(cb[0]), .c_limit(cl[0]), .c_step(cst[0]),
    .c_done(cd[0]), .c_valid(cv[0]), .c_0(c0[0]), .c_1(c1[0])
  );

  gen_sum_caller #(.WIDTH(32), .STALL_EVERY(2)) u_dut1 (
    ._clock(clk), ._reset(rst), ._start(start), ._ready(rdy),
    .base(base), .limit(limit), .step(step),
    ._done(od[1]), ._valid(ov[1]), ._0(o0[1]), ._1(o1[1]),
    .c_start(cs[1]), .c_ready(cr[1]), .c_base(cb[1]), .c_limit(cl[1]), .c_step(cst[1]),
    .c_done(cd[1]), .c_valid(cv[1]), .c_0(c0[1]), .c_1(c1[1])
  );

  // Range child: yields cur while cur < limit; wrap_mode yields 0x7FFFFFFF
  // and raises done together with the last yield.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cv[i] = act[i] && ($signed(cur[i]) < $signed(lim[i]));
      if (wrap_mode)
        cd[i] = act[i] && ($signed(cur[i] + stp[i]) >= $signed(lim[i]));
      else
        cd[i] = act[i] && ($signed(cur[i]) >= $signed(lim[i]));
      c0[i] = wrap_mode ? 32'h7FFF_FFFF : cur[i];
      c1[i] = cur[i];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        act[i] <= 1'b0; cur[i] <= 32'd0; lim[i] <= 32'd0; stp[i] <= 32'd0; yields[i] <= 0;
      end else if (cs[i]) begin
        act[i] <= 1'b1; cur[i] <= cb[i]; lim[i] <= cl[i]; stp[i] <= cst[i]; yields[i] <= 0;
      end else if (act[i]) begin
        if (cv[i] && cr[i]) begin
          cur[i]    <= cur[i] + stp[i];
          yields[i] <= yields[i] + 1;
        end
        if (cd[i] && cr[i]) act[i] <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_valid"}, 32'(ov[i]), 32'd0);
      chk({tag, "_done"},  32'(od[i]), 32'd0);
      chk({tag, "_0"},     o0[i], 32'd0);
      chk({tag, "_1"},     o1[i], 32'd0);
      chk({tag, "_cstart"}, 32'(cs[i]), 32'd0);
      chk({tag, "_cready"}, 32'(cr[i]), 32'd0);
      chk({tag, "_cbase"},  cb[i], 32'd0);
      chk({tag, "_climit"}, cl[i], 32'd0);
      chk({tag, "_cstep"},  cst[i], 32'd0);
    end
  endtask

  // One call: pulse _start, then watch a bounded window on both callers.
  task automatic run(input string tag, input logic [31:0] b, input logic [31:0] l,
                     input logic [31:0] s, input logic wrap, input logic mid_start,
                     input logic [31:0] exp_sum, input logic [31:0] exp_cnt,
                     input int lat0, input int lat1, input int st0, input int st1,
                     input logic hold);
    int cs_n[2], cs_t[2], v_t[2], v_n[2], st[2];
    logic got[2];
    int lat[2], exp_st[2];
    lat[0] = lat0; lat[1] = lat1; exp_st[0] = st0; exp_st[1] = st1;
    for (int i = 0; i < 2; i++) begin
      cs_n[i] = 0; cs_t[i] = 0; v_t[i] = 0; v_n[i] = 0; st[i] = 0; got[i] = 1'b0;
    end
    wrap_mode = wrap;
    rdy = !hold;
    base = b; limit = l; step = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 30; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (cs[i]) begin
          cs_n[i]++;
          cs_t[i] = k;
          chk({tag, "_cbase"},  cb[i], b);
          chk({tag, "_climit"}, cl[i], l);
          chk({tag, "_cstep"},  cst[i], s);
        end
        if (ov[i]) begin
          v_n[i]++;
          if (!got[i]) begin
            got[i] = 1'b1;
            v_t[i] = k;
            chk({tag, "_sum"},  o0[i], exp_sum);
            chk({tag, "_cnt"},  o1[i], exp_cnt);
            chk({tag, "_done"}, 32'(od[i]), 32'd1);
          end
        end
        if (cs_n[i] > 0 && !got[i] && !cr[i]) st[i]++;
      end
      if (hold && got[0] && got[1]) break;
      if (mid_start && k == 2) begin
        start = 1'b1; base = 32'd100; limit = 32'd200; step = 32'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_got"},     32'(got[i]), 32'd1);
      chk({tag, "_cstartn"}, 32'(cs_n[i]), 32'd1);
      chk({tag, "_latency"}, 32'(v_t[i] - cs_t[i]), 32'(lat[i]));
      chk({tag, "_stalls"},  32'(st[i]), 32'(exp_st[i]));
      chk({tag, "_cbase_end"}, cb[i], b);
      if (!hold) chk({tag, "_validcyc"}, 32'(v_n[i]), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rdy = 1'b1; wrap_mode = 1'b0;
    base = 32'd0; limit = 32'd0; step = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;

    run("basic", 32'd0, 32'd10, 32'd2, 1'b0, 1'b0, 32'd20, 32'd5, 7, 9, 0, 2, 1'b0);
    run("empty", 32'd5, 32'd5, 32'd1, 1'b0, 1'b0, 32'd0, 32'd0, 2, 2, 0, 0, 1'b0);

    run("hold", 32'd0, 32'd10, 32'd2, 1'b0, 1'b0, 32'd20, 32'd5, 7, 9, 0, 2, 1'b1);
    for (int j = 0; j < 3; j++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        chk("hold_valid", 32'(ov[i]), 32'd1);
        chk("hold_done",  32'(od[i]), 32'd1);
        chk("hold_sum",   o0[i], 32'd20);
        chk("hold_cnt",   o1[i], 32'd5);
      end
    end
    rdy = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      chk("handoff_valid", 32'(ov[i]), 32'd0);
      chk("handoff_sum_kept", o0[i], 32'd20);
    end
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) chk("handoff_idle", 32'(ov[i]), 32'd0);

    run("midstart", 32'd0, 32'd10, 32'd2, 1'b0, 1'b1, 32'd20, 32'd5, 7, 9, 0, 2, 1'b0);
    for (int r = 0; r < 3; r++)
      run("b2b", 32'd0, 32'd10, 32'd2, 1'b0, 1'b0, 32'd20, 32'd5, 7, 9, 0, 2, 1'b0);

    base = 32'd0; limit = 32'd10; step = 32'd2; wrap_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (yields[0] < 2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rst_wait", 32'(n < 20), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_zero("midrst");
    run("after_rst", 32'd0, 32'd10, 32'd2, 1'b0, 1'b0, 32'd20, 32'd5, 7, 9, 0, 2, 1'b0);

    run("wrap", 32'd0, 32'd2, 32'd1, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'd2, 3, 3, 0, 0, 1'b0);
    wrap_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
